// File: rtl/if_pc_fetch.sv
// ---------------------------------------------------------------------------
// if_pc_fetch -- instruction fetch stage.
//
// Owns the program counter and issues instruction-bus reads. It delivers
// instruction/PC pairs to the IF/ID register. Redirects arrive from the EX
// stage branch unit. A redirect discards wrong-path fetches and pulses a
// one-cycle flush. A one-entry skid buffer absorbs a bus response that lands
// while the downstream stage is holding.
//
// Ports:
//   clk_in            rising-edge clock
//   reset_n_in        asynchronous active-low reset
//   jump_enable_in    redirect request, sampled at the clock edge
//   jump_address_in   redirect target
//   hold_in           downstream stall: inst_out is not consumed this cycle
//   ibus_req_out      fetch request, held stable until ibus_ack_in
//   ibus_addr_out     fetch address, held stable until ibus_ack_in
//   ibus_ack_in       transfer completes this cycle
//   ibus_rdata_in     instruction word, valid with ibus_ack_in
//   inst_out          instruction to IF/ID (NOP_INST when invalid)
//   inst_address_out  PC of inst_out
//   inst_valid_out    inst_out is valid
//   flush_out         one-cycle pulse that flushes IF/ID and ID/EX
//   misalign_err_out  sticky misaligned-jump error (IF_MISALIGN_CHK_EN only)
//
// Optional feature macro: IF_MISALIGN_CHK_EN
//   Undefined: the low two bits of a jump target are forced to zero.
//   Defined:   a jump whose target is not word-aligned flushes as usual.
//              Any outstanding transfer is then drained, and the stage parks
//              in ERR with misalign_err_out set until reset.
// ---------------------------------------------------------------------------
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif
`ifndef ZERO
`define ZERO 32'h0000_0000
`endif

module if_pc_fetch #(
  parameter logic [`ADDR_WIDTH-1:0] RESET_PC = 32'h0000_0000,
  parameter logic [`DATA_WIDTH-1:0] NOP_INST = 32'h0000_0013
) (
  input  logic                   clk_in,
  input  logic                   reset_n_in,
  input  logic                   jump_enable_in,
  input  logic [`ADDR_WIDTH-1:0] jump_address_in,
  input  logic                   hold_in,
  output logic                   ibus_req_out,
  output logic [`ADDR_WIDTH-1:0] ibus_addr_out,
  input  logic                   ibus_ack_in,
  input  logic [`DATA_WIDTH-1:0] ibus_rdata_in,
  output logic [`DATA_WIDTH-1:0] inst_out,
  output logic [`ADDR_WIDTH-1:0] inst_address_out,
  output logic                   inst_valid_out,
  output logic                   flush_out
`ifdef IF_MISALIGN_CHK_EN
  ,
  output logic                   misalign_err_out
`endif
);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    KILL
`ifdef IF_MISALIGN_CHK_EN
    ,
    ERR
`endif
  } state_t;

  state_t                 state;
  logic [`ADDR_WIDTH-1:0] pc;
  logic [`ADDR_WIDTH-1:0] redirect_pc;
  logic                   skid_valid;
  logic [`DATA_WIDTH-1:0] skid_inst;
  logic [`ADDR_WIDTH-1:0] skid_addr;

  logic [`ADDR_WIDTH-1:0] jump_target;
  logic                   jump_taken;
  logic                   req_waiting;
  logic                   fetch_ack;

  // The PC never moves while a request is outstanding. A killed request is
  // also still addressed by pc, because the target waits in redirect_pc. So
  // the bus address is simply the PC register. The bus request is a pure
  // decode of registered state and has no input-to-output path.
  assign ibus_addr_out = pc;
  assign ibus_req_out  = ((state == FETCH) && !skid_valid) || (state == KILL);

  assign jump_target = {jump_address_in[`ADDR_WIDTH-1:2], 2'b00};
  assign req_waiting = ibus_req_out && !ibus_ack_in;
  assign fetch_ack   = (state == FETCH) && ibus_req_out && ibus_ack_in;

`ifdef IF_MISALIGN_CHK_EN
  logic misaligned;
  logic kill_to_err;  // the pending redirect was misaligned: park in ERR after drain

  assign misaligned       = (jump_address_in[1:0] != 2'b00);
  assign jump_taken       = jump_enable_in && (state != ERR);
  assign misalign_err_out = (state == ERR);
`else
  logic unused_addr_bits;

  assign unused_addr_bits = &{1'b0, jump_address_in[1:0]};
  assign jump_taken       = jump_enable_in;
`endif

  // NOTE: every register here is state, so this block uses non-blocking
  // assignments only. A read anywhere in the block always sees the value
  // from before the clock edge.
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      state            <= IDLE;
      pc               <= RESET_PC;
      redirect_pc      <= RESET_PC;
      skid_valid       <= 1'b0;
      skid_inst        <= NOP_INST;
      skid_addr        <= `ZERO;
      inst_out         <= NOP_INST;
      inst_address_out <= `ZERO;
      inst_valid_out   <= 1'b0;
      flush_out        <= 1'b0;
`ifdef IF_MISALIGN_CHK_EN
      kill_to_err      <= 1'b0;
`endif
    end else begin
      flush_out <= 1'b0;
      if (jump_taken) begin
        // A redirect outranks both hold and ack. Everything in flight is wrong-path.
        flush_out      <= 1'b1;
        inst_valid_out <= 1'b0;
        inst_out       <= NOP_INST;
        skid_valid     <= 1'b0;
        if (req_waiting) begin
          // The bus handshake cannot be abandoned. Wait for its ack in KILL.
          redirect_pc <= jump_target;
          state       <= KILL;
`ifdef IF_MISALIGN_CHK_EN
          kill_to_err <= misaligned;
`endif
        end else begin
          pc    <= jump_target;
`ifdef IF_MISALIGN_CHK_EN
          state <= misaligned ? ERR : FETCH;
`else
          state <= FETCH;
`endif
        end
      end else begin
        case (state)
          IDLE:  state <= FETCH;
          FETCH: if (fetch_ack) pc <= pc + `ADDR_WIDTH'(4);
          KILL: begin
            if (ibus_ack_in) begin
              pc    <= redirect_pc;
`ifdef IF_MISALIGN_CHK_EN
              state <= kill_to_err ? ERR : FETCH;
`else
              state <= FETCH;
`endif
            end
          end
          default: state <= state;
        endcase

        // Output slot. A fresh word goes straight out if the slot is free or
        // is being consumed. Otherwise the word is parked in the skid buffer.
        // The bus request drops until the skid buffer is drained.
        if (fetch_ack && (!inst_valid_out || !hold_in)) begin
          inst_out         <= ibus_rdata_in;
          inst_address_out <= pc;
          inst_valid_out   <= 1'b1;
        end else if (fetch_ack) begin
          skid_valid <= 1'b1;
          skid_inst  <= ibus_rdata_in;
          skid_addr  <= pc;
        end else if (!hold_in) begin
          if (skid_valid) begin
            inst_out         <= skid_inst;
            inst_address_out <= skid_addr;
            inst_valid_out   <= 1'b1;
            skid_valid       <= 1'b0;
          end else begin
            inst_out       <= NOP_INST;
            inst_valid_out <= 1'b0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_if_pc_fetch.sv
// ---------------------------------------------------------------------------
// tb_if_pc_fetch -- directed, table-driven bench for if_pc_fetch.
//
// Each table row holds the inputs driven during one clock cycle. It also
// holds the outputs expected during that same cycle, which result from
// earlier edges. Hand-written sequences after the table cover asynchronous
// reset in the middle of a transfer. When IF_MISALIGN_CHK_EN is defined,
// they also cover the misaligned-jump error state.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_if_pc_fetch;

  localparam logic [31:0] NOP  = 32'h0000_0013;
  localparam logic [31:0] JUNK = 32'hDEAD_BEEF;
`ifdef IF_MISALIGN_CHK_EN
  localparam logic [31:0] MIS_TGT = 32'h0000_0100;
`else
  localparam logic [31:0] MIS_TGT = 32'h0000_0102;
`endif

  logic        clk;
  logic        rst_n;
  logic        jump_en;
  logic [31:0] jump_addr;
  logic        hold;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] rdata;
  logic [31:0] inst;
  logic [31:0] inst_addr;
  logic        valid;
  logic        flush;
`ifdef IF_MISALIGN_CHK_EN
  logic        mis_err;
`endif

  if_pc_fetch dut (
    .clk_in           (clk),
    .reset_n_in       (rst_n),
    .jump_enable_in   (jump_en),
    .jump_address_in  (jump_addr),
    .hold_in          (hold),
    .ibus_req_out     (req),
    .ibus_addr_out    (addr),
    .ibus_ack_in      (ack),
    .ibus_rdata_in    (rdata),
    .inst_out         (inst),
    .inst_address_out (inst_addr),
    .inst_valid_out   (valid),
    .flush_out        (flush)
`ifdef IF_MISALIGN_CHK_EN
    ,
    .misalign_err_out (mis_err)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        jump;
    logic [31:0] jaddr;
    logic        hold;
    logic        ack;
    logic [31:0] rdata;
    logic        e_req;
    logic [31:0] e_addr;
    logic        e_valid;
    logic [31:0] e_iaddr;
    logic [31:0] e_inst;
    logic        e_flush;
  } vec_t;

  vec_t vecs[$];
  int   n_vec  = 0;
  int   n_fail = 0;

  function automatic logic [31:0] inst_of(input logic [31:0] a);
    return {8'hA5, a[23:0]};
  endfunction

  task automatic add(input logic j, input logic [31:0] ja, input logic h,
                     input logic a, input logic [31:0] rd,
                     input logic er, input logic [31:0] ea, input logic ev,
                     input logic [31:0] eia, input logic [31:0] ei,
                     input logic ef);
    vec_t v;
    v.jump = j;  v.jaddr = ja;  v.hold = h;  v.ack = a;  v.rdata = rd;
    v.e_req = er;  v.e_addr = ea;  v.e_valid = ev;
    v.e_iaddr = eia;  v.e_inst = ei;  v.e_flush = ef;
    vecs.push_back(v);
  endtask

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic check_outputs(input string tag, input logic er,
                               input logic [31:0] ea, input logic ev,
                               input logic [31:0] eia, input logic [31:0] ei,
                               input logic ef);
    check({tag, " req"},       32'(req),   32'(er));
    check({tag, " addr"},      addr,       ea);
    check({tag, " valid"},     32'(valid), 32'(ev));
    check({tag, " inst_addr"}, inst_addr,  eia);
    check({tag, " inst"},      inst,       ei);
    check({tag, " flush"},     32'(flush), 32'(ef));
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    //   jmp jaddr          hld ack rdata                  req addr           vld iaddr          inst                    flush
    add(0, 32'h0,          0, 0, 32'h0,                   0, 32'h0,          0, 32'h0,          NOP,                    0); // c0 IDLE
    add(0, 32'h0,          0, 1, inst_of(32'h0),          1, 32'h0,          0, 32'h0,          NOP,                    0); // c1
    add(0, 32'h0,          1, 1, inst_of(32'h4),          1, 32'h4,          1, 32'h0,          inst_of(32'h0),         0); // c2 0x4 to skid
    add(0, 32'h0,          1, 0, 32'h0,                   0, 32'h8,          1, 32'h0,          inst_of(32'h0),         0); // c3
    add(0, 32'h0,          1, 0, 32'h0,                   0, 32'h8,          1, 32'h0,          inst_of(32'h0),         0); // c4
    add(0, 32'h0,          0, 0, 32'h0,                   0, 32'h8,          1, 32'h0,          inst_of(32'h0),         0); // c5 release
    add(1, 32'h100,        0, 0, 32'h0,                   1, 32'h8,          1, 32'h4,          inst_of(32'h4),         0); // c6 jump, wait
    add(0, 32'h0,          0, 0, 32'h0,                   1, 32'h8,          0, 32'h4,          NOP,                    1); // c7 KILL
    add(0, 32'h0,          0, 0, 32'h0,                   1, 32'h8,          0, 32'h4,          NOP,                    0); // c8
    add(0, 32'h0,          0, 1, JUNK,                    1, 32'h8,          0, 32'h4,          NOP,                    0); // c9 killed ack
    add(0, 32'h0,          0, 1, inst_of(32'h100),        1, 32'h100,        0, 32'h4,          NOP,                    0); // c10
    add(0, 32'h0,          0, 1, inst_of(32'h104),        1, 32'h104,        1, 32'h100,        inst_of(32'h100),       0); // c11
    add(1, 32'h200,        1, 1, inst_of(32'h108),        1, 32'h108,        1, 32'h104,        inst_of(32'h104),       0); // c12 jump+ack+hold
    add(0, 32'h0,          0, 1, inst_of(32'h200),        1, 32'h200,        0, 32'h104,        NOP,                    1); // c13
    add(1, MIS_TGT,        0, 0, 32'h0,                   1, 32'h204,        1, 32'h200,        inst_of(32'h200),       0); // c14 low bits
    add(0, 32'h0,          0, 1, JUNK,                    1, 32'h204,        0, 32'h200,        NOP,                    1); // c15
    add(1, 32'hFFFF_FFFC,  0, 0, 32'h0,                   1, 32'h100,        0, 32'h200,        NOP,                    0); // c16
    add(1, 32'hFFFF_FFF8,  0, 0, 32'h0,                   1, 32'h100,        0, 32'h200,        NOP,                    1); // c17 re-jump in KILL
    add(0, 32'h0,          0, 1, JUNK,                    1, 32'h100,        0, 32'h200,        NOP,                    1); // c18
    add(0, 32'h0,          0, 1, inst_of(32'hFFFF_FFF8),  1, 32'hFFFF_FFF8,  0, 32'h200,        NOP,                    0); // c19
    add(0, 32'h0,          0, 1, inst_of(32'hFFFF_FFFC),  1, 32'hFFFF_FFFC,  1, 32'hFFFF_FFF8,  inst_of(32'hFFFF_FFF8), 0); // c20
    add(0, 32'h0,          0, 0, 32'h0,                   1, 32'h0,          1, 32'hFFFF_FFFC,  inst_of(32'hFFFF_FFFC), 0); // c21 wrap
    add(0, 32'h0,          0, 0, 32'h0,                   1, 32'h0,          0, 32'hFFFF_FFFC,  NOP,                    0); // c22

    rst_n = 1'b0;  jump_en = 1'b0;  jump_addr = 32'h0;
    hold  = 1'b0;  ack     = 1'b0;  rdata     = 32'h0;
    step();
    step();
    check_outputs("reset", 1'b0, 32'h0, 1'b0, 32'h0, NOP, 1'b0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      jump_en   = vecs[i].jump;
      jump_addr = vecs[i].jaddr;
      hold      = vecs[i].hold;
      ack       = vecs[i].ack;
      rdata     = vecs[i].rdata;
      check_outputs($sformatf("v%0d", i), vecs[i].e_req, vecs[i].e_addr,
                    vecs[i].e_valid, vecs[i].e_iaddr, vecs[i].e_inst,
                    vecs[i].e_flush);
      step();
    end
    jump_en = 1'b0;  hold = 1'b0;  ack = 1'b0;

    // Back-to-back fetches up to 0x10, then reset while 0x10 is waiting.
    for (int k = 0; k < 4; k++) begin
      ack   = 1'b1;
      rdata = inst_of(32'(4 * k));
      check($sformatf("seq addr %0d", k), addr, 32'(4 * k));
      step();
    end
    ack = 1'b0;
    check("wait req", 32'(req), 32'h1);
    check("wait addr", addr, 32'h10);
    #2 rst_n = 1'b0;
    #1;
    check_outputs("async rst", 1'b0, 32'h0, 1'b0, 32'h0, NOP, 1'b0);
    ack   = 1'b1;
    rdata = JUNK;
    step();
    check("rst ack ignored req", 32'(req), 32'h0);
    check("rst ack ignored valid", 32'(valid), 32'h0);
    ack   = 1'b0;
    rst_n = 1'b1;
    check("post rst idle req", 32'(req), 32'h0);
    step();
    check("restart req", 32'(req), 32'h1);
    check("restart addr", addr, 32'h0);
    ack   = 1'b1;
    rdata = inst_of(32'h0);
    step();
    ack = 1'b0;
    check_outputs("restart out", 1'b1, 32'h4, 1'b1, 32'h0, inst_of(32'h0), 1'b0);

`ifdef IF_MISALIGN_CHK_EN
    // Misaligned jump while 0x4 is outstanding. The transfer drains, then ERR.
    check("err clear", 32'(mis_err), 32'h0);
    jump_en   = 1'b1;
    jump_addr = 32'h102;
    step();
    jump_en = 1'b0;
    check("mis kill flush", 32'(flush), 32'h1);
    check("mis kill addr", addr, 32'h4);
    check("mis kill err", 32'(mis_err), 32'h0);
    ack   = 1'b1;
    rdata = JUNK;
    step();
    ack = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("err flag %0d", k), 32'(mis_err), 32'h1);
      check($sformatf("err req %0d", k), 32'(req), 32'h0);
      check($sformatf("err valid %0d", k), 32'(valid), 32'h0);
      step();
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
